// File: rtl/digital_lock_top.sv
// -----------------------------------------------------------------------------
// digital_lock_top
//
// Four-button combination lock, board top level. Each button is synchronized,
// debounced and rising-edge detected. A state machine follows entry of the
// code S-W-E-W. led shows how far the entry has progressed, and rgb shows
// whether the lock is locked (red) or unlocked (green).
//
// Optional build macro: DIGITAL_LOCK_LOCKOUT_EN
//   When defined, the third wrong attempt puts the lock into a LOCKOUT state
//   (blue) for LOCKOUT_CYCLES clocks. In that state every press is ignored.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-low
//   btn[3:0]  buttons N,S,E,W (bit 3..0), active-high, asynchronous to clk
//   sw[3:0]   sw[0] = synchronous relock/clear (active-high), sw[3:1] unused
//   led[3:0]  entry progress: 0000, 0001, 0011, 0111, 1111
//   rgb[2:0]  {red, green, blue} status colour
// -----------------------------------------------------------------------------
module digital_lock_top #(
  parameter int clk_freq       = 125_000_000,
  parameter int stable_time    = 1,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [3:0] sw,
  output logic [3:0] led,
  output logic [2:0] rgb
);

  localparam int DEB_RAW         = (clk_freq / 1_000_000 * stable_time) / 1000;
  localparam int DEBOUNCE_CYCLES = (DEB_RAW < 1) ? 1 : DEB_RAW;
  localparam int DEB_CNT_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_CNT_W-1:0] DEB_CNT_MAX = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    GOT_S    = 3'd1,
    GOT_SW   = 3'd2,
    GOT_SWE  = 3'd3,
    UNLOCKED = 3'd4
`ifdef DIGITAL_LOCK_LOCKOUT_EN
    ,
    LOCKOUT  = 3'd5
`endif
  } state_e;

  logic unused_sw;
  assign unused_sw = ^sw[3:1];

  // ---------------------------------------------------------------------------
  // Input path: two-flop synchronizer, debouncer and edge register per bit
  // ---------------------------------------------------------------------------
  logic [3:0]           sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [DEB_CNT_W-1:0] deb_cnt_q [4];

  // NOTE: every register here is updated with <=. All flops then sample
  // pre-edge values, so the synchronizer chain really is two stages deep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_prev_q <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
    end
  end

  // The debounced level flips only after the synchronized input has
  // disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
  // NOTE: the per-bit counter array is only four small registers, so it
  // gets a reset like any other flop. It does not behave as a memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (deb_cnt_q[i] == DEB_CNT_MAX) begin
            deb_q[i]     <= sync2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + DEB_CNT_W'(1);
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  // One-cycle press pulses. A valid press has exactly one button.
  logic [3:0] press;
  logic       any_press, one_press;
  logic       p_n, p_s, p_e, p_w;

  assign press     = deb_q & ~deb_prev_q;
  assign any_press = |press;
  assign one_press = $onehot(press);
  assign p_n       = one_press & press[3];
  assign p_s       = one_press & press[2];
  assign p_e       = one_press & press[1];
  assign p_w       = one_press & press[0];

  // ---------------------------------------------------------------------------
  // Lock state machine
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

`ifdef DIGITAL_LOCK_LOCKOUT_EN
  localparam int LO_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LO_W-1:0] LO_MAX = LO_W'(LOCKOUT_CYCLES - 1);

  logic [1:0]      fail_q, fail_d;
  logic [LO_W-1:0] lo_cnt_q, lo_cnt_d;
  logic            wrong;
`else
  logic [31:0] unused_lockout;
  assign unused_lockout = 32'(LOCKOUT_CYCLES);
`endif

  // NOTE: each signal driven here gets its default value first. Then no
  // path through the case statements leaves a value unassigned, and no latch
  // can be inferred.
  always_comb begin
    state_d = state_q;
`ifdef DIGITAL_LOCK_LOCKOUT_EN
    fail_d   = fail_q;
    lo_cnt_d = '0;
    wrong    = 1'b0;
`endif
    if (sw[0]) begin
      state_d = LOCKED;
    end else begin
      case (state_q)
        LOCKED:   if (any_press) state_d = p_s ? GOT_S : LOCKED;
        GOT_S:    if (any_press) state_d = p_w ? GOT_SW   : (p_s ? GOT_S : LOCKED);
        GOT_SW:   if (any_press) state_d = p_e ? GOT_SWE  : (p_s ? GOT_S : LOCKED);
        GOT_SWE:  if (any_press) state_d = p_w ? UNLOCKED : (p_s ? GOT_S : LOCKED);
        // Only a clean N relocks. Other presses, including multi-button
        // presses, leave the lock open.
        UNLOCKED: if (p_n) state_d = LOCKED;
`ifdef DIGITAL_LOCK_LOCKOUT_EN
        LOCKOUT: begin
          if (lo_cnt_q == LO_MAX) state_d = LOCKED;
          else                    lo_cnt_d = lo_cnt_q + LO_W'(1);
        end
`endif
        default:  state_d = LOCKED;
      endcase
    end

`ifdef DIGITAL_LOCK_LOCKOUT_EN
    // A wrong attempt is any press that sends an entry state back to LOCKED.
    wrong = any_press && !sw[0] && (state_d == LOCKED) &&
            (state_q inside {LOCKED, GOT_S, GOT_SW, GOT_SWE});
    if (sw[0] || state_d == UNLOCKED) begin
      fail_d = '0;
    end else if (wrong) begin
      if (fail_q == 2'd2) begin
        state_d = LOCKOUT;
        fail_d  = '0;
      end else begin
        fail_d = fail_q + 2'd1;
      end
    end
`endif
  end

  // The outputs decode from the next state and are registered in the same
  // edge as the state register, so led and rgb never lag the state.
  logic [3:0] led_q, led_d;
  logic [2:0] rgb_q, rgb_d;

  always_comb begin
    led_d = 4'b0000;
    rgb_d = 3'b100;
    case (state_d)
      GOT_S:    led_d = 4'b0001;
      GOT_SW:   led_d = 4'b0011;
      GOT_SWE:  led_d = 4'b0111;
      UNLOCKED: begin
        led_d = 4'b1111;
        rgb_d = 3'b010;
      end
`ifdef DIGITAL_LOCK_LOCKOUT_EN
      LOCKOUT:  rgb_d = 3'b001;
`endif
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOCKED;
      led_q   <= 4'b0000;
      rgb_q   <= 3'b100;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      rgb_q   <= rgb_d;
    end
  end

`ifdef DIGITAL_LOCK_LOCKOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_q   <= '0;
      lo_cnt_q <= '0;
    end else begin
      fail_q   <= fail_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end
`endif

  assign led = led_q;
  assign rgb = rgb_q;

endmodule

// File: tb/tb_digital_lock_top.sv
// -----------------------------------------------------------------------------
// tb_digital_lock_top
//
// Self-checking bench for digital_lock_top. It runs a table of directed
// button/switch records, a few hand-written timing sequences, and a
// randomized run. The randomized run is checked against a progress-count
// model of the S-W-E-W code.
// -----------------------------------------------------------------------------
module tb_digital_lock_top;

  localparam logic [3:0] BN = 4'b1000, BS = 4'b0100, BE = 4'b0010, BW = 4'b0001;
  localparam int LOCKOUT_CYCLES = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn, sw;
  logic [3:0] led;
  logic [2:0] rgb;

  int total = 0;
  int bad   = 0;

  digital_lock_top dut (
    .clk(clk), .rst(rst), .btn(btn), .sw(sw), .led(led), .rgb(rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       sw0;
    int         hold;
    logic [3:0] led;
    logic [2:0] rgb;
    string      name;
  } vec_t;

  vec_t vecs[$];

  logic [3:0] code [4];

  task automatic check(string name, logic [3:0] el, logic [2:0] er);
    total++;
    if (led !== el || rgb !== er) begin
      bad++;
      $display("FAIL %s: led=%b rgb=%b, expected led=%b rgb=%b", name, led, rgb, el, er);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge, and inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a record for 'hold' cycles, then idle long enough for the press
  // to pass the input pipeline.
  task automatic apply(logic [3:0] b, logic s0, int hold);
    btn = b;
    sw  = {3'b000, s0};
    repeat (hold) tick();
    btn = '0;
    sw  = '0;
    repeat (5) tick();
  endtask

  // Reference model: p = number of code symbols matched so far, 4 = open.
  function automatic int next_prog(int p, logic [3:0] pr);
    int n;
    n = $countones(pr);
    if (n == 0) return p;
    if (p == 4) return (n == 1 && pr[3]) ? 0 : 4;
    if (n > 1) return 0;
    if (pr == code[p]) return p + 1;
    if (pr == BS) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] led_of(int p);
    return 4'((1 << p) - 1);
  endfunction

  function automatic logic [2:0] rgb_of(int p);
    return (p == 4) ? 3'b010 : 3'b100;
  endfunction

  initial begin
    logic [3:0] v, prev, pr;
    int         prog, r;

    code[0] = BS; code[1] = BW; code[2] = BE; code[3] = BW;

    rst = 1'b0;
    btn = '0;
    sw  = '0;
    #12;
    check("reset", 4'b0000, 3'b100);
    rst = 1'b1;
    tick();

    // Latency: the S press must show on led after four clock edges.
    btn = BS;
    tick();
    btn = '0;
    repeat (3) tick();
    check("latency4", 4'b0001, 3'b100);
    repeat (3) tick();

`ifdef DIGITAL_LOCK_LOCKOUT_EN
    apply('0, 1'b1, 1);  check("clear", 4'b0000, 3'b100);
    apply(BW, 1'b0, 1);  check("wrong1", 4'b0000, 3'b100);
    apply(BE, 1'b0, 1);  check("wrong2", 4'b0000, 3'b100);
    apply(BE, 1'b0, 1);  check("lockout_in", 4'b0000, 3'b001);
    apply(BS, 1'b0, 1);  check("lockout_s", 4'b0000, 3'b001);
    repeat (LOCKOUT_CYCLES) tick();
    check("lockout_out", 4'b0000, 3'b100);
    apply(BS, 1'b0, 1);  check("after_lockout", 4'b0001, 3'b100);
    apply(BN, 1'b0, 1);  apply(BN, 1'b0, 1);
    apply(BE, 1'b1, 6);  check("sw_abort_cnt", 4'b0000, 3'b100);
    apply(BS, 1'b0, 1);  check("post_abort_s", 4'b0001, 3'b100);
`else
    vecs.push_back('{4'b0000, 1'b1, 1,  4'b0000, 3'b100, "clear"});
    vecs.push_back('{BS,      1'b0, 1,  4'b0001, 3'b100, "u_S"});
    vecs.push_back('{BW,      1'b0, 1,  4'b0011, 3'b100, "u_W"});
    vecs.push_back('{BE,      1'b0, 1,  4'b0111, 3'b100, "u_E"});
    vecs.push_back('{BW,      1'b0, 1,  4'b1111, 3'b010, "u_W2"});
    vecs.push_back('{BE,      1'b0, 1,  4'b1111, 3'b010, "open_E"});
    vecs.push_back('{BW,      1'b0, 1,  4'b1111, 3'b010, "open_W"});
    vecs.push_back('{4'b0110, 1'b0, 1,  4'b1111, 3'b010, "open_multi"});
    vecs.push_back('{BN,      1'b0, 1,  4'b0000, 3'b100, "relock_N"});
    vecs.push_back('{BW,      1'b0, 1,  4'b0000, 3'b100, "ws_W"});
    vecs.push_back('{BE,      1'b0, 1,  4'b0000, 3'b100, "ws_E"});
    vecs.push_back('{BE,      1'b0, 1,  4'b0000, 3'b100, "ws_E2"});
    vecs.push_back('{BS,      1'b0, 1,  4'b0001, 3'b100, "wm_S"});
    vecs.push_back('{BW,      1'b0, 1,  4'b0011, 3'b100, "wm_W"});
    vecs.push_back('{BE,      1'b0, 1,  4'b0111, 3'b100, "wm_E"});
    vecs.push_back('{BN,      1'b0, 1,  4'b0000, 3'b100, "wm_N"});
    vecs.push_back('{BN,      1'b0, 1,  4'b0000, 3'b100, "wm_N2"});
    vecs.push_back('{BS,      1'b0, 1,  4'b0001, 3'b100, "h_S"});
    vecs.push_back('{BW,      1'b0, 20, 4'b0011, 3'b100, "held_W20"});
    vecs.push_back('{BS,      1'b0, 1,  4'b0001, 3'b100, "sw_back_S"});
    vecs.push_back('{4'b1010, 1'b0, 1,  4'b0000, 3'b100, "multi_1010"});
    vecs.push_back('{BS,      1'b0, 1,  4'b0001, 3'b100, "p_S"});
    vecs.push_back('{BW,      1'b0, 1,  4'b0011, 3'b100, "p_W"});
    vecs.push_back('{BE,      1'b1, 6,  4'b0000, 3'b100, "sw_prio"});
    vecs.push_back('{BS,      1'b0, 1,  4'b0001, 3'b100, "c_S"});
    vecs.push_back('{BW,      1'b0, 1,  4'b0011, 3'b100, "c_W"});
    vecs.push_back('{BE,      1'b0, 1,  4'b0111, 3'b100, "c_E"});
    vecs.push_back('{BW,      1'b0, 1,  4'b1111, 3'b010, "c_W2"});
    vecs.push_back('{4'b0000, 1'b1, 1,  4'b0000, 3'b100, "sw_relock"});

    foreach (vecs[i]) begin
      apply(vecs[i].btn, vecs[i].sw0, vecs[i].hold);
      check(vecs[i].name, vecs[i].led, vecs[i].rgb);
    end

    // Randomized run. Each vector is held long enough to pass the input
    // path. A press is a bit that rises between consecutive vectors.
    prog = 0;
    prev = '0;
    for (int step = 0; step < 300; step++) begin
      if ($urandom_range(9) == 0) begin
        sw = 4'b0001;
        tick();
        sw = '0;
        prog = 0;
        repeat (5) tick();
      end else begin
        r = $urandom_range(9);
        if (r < 3)                   v = '0;
        else if (r < 6 && prog < 4)  v = code[prog];
        else if (r < 9)              v = 4'b0001 << $urandom_range(3);
        else                         v = 4'($urandom_range(15));
        pr   = v & ~prev;
        btn  = v;
        sw   = {3'($urandom_range(7)), 1'b0};
        repeat ($urandom_range(5, 8)) tick();
        prev = v;
        prog = next_prog(prog, pr);
      end
      check("random", led_of(prog), rgb_of(prog));
    end
    btn = '0;
    sw  = '0;
    repeat (5) tick();

    // Asynchronous reset from the open state, checked with no clock edge.
    apply(BS, 1'b0, 1); apply(BW, 1'b0, 1); apply(BE, 1'b0, 1); apply(BW, 1'b0, 1);
    check("reopen", 4'b1111, 3'b010);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 4'b0000, 3'b100);
    #2;
    rst = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digital_lock_top.md
Name: digital_lock_top

Overview:
- Four-button combination lock FPGA top level.
- Buttons btn[3:0] (N,S,E,W) are synchronized, debounced and rising-edge detected.
- A state machine tracks entry of the code S-W-E-W; led[3:0] shows progress, rgb shows locked/unlocked.
- Sits directly on board pins: buttons, switches, LEDs, RGB LED.

Parameters:
- clk_freq, 125_000_000, clock frequency in Hz.
- stable_time, 1, debounce stability time in ns. DEBOUNCE_CYCLES = max(1, (clk_freq/1_000_000 * stable_time)/1000).
- LOCKOUT_CYCLES, 1000, lockout duration in clocks (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- btn  in  4  buttons: btn[3]=N, btn[2]=S, btn[1]=E, btn[0]=W; active-high, asynchronous to clk.
- sw  in  4  sw[0] = synchronous relock/clear, active-high; sw[3:1] unused.
- led  out  4  entry progress indicator.
- rgb  out  3  status colour: rgb[2]=red, rgb[1]=green, rgb[0]=blue.

Behaviour:
- Reset: rst low asynchronously forces the following; these are also the reset values:
  - state=LOCKED, synchronizers/debouncers/edge registers=0.
  - led=4'b0000, rgb=3'b100.
- Input path, per button bit:
  - 2-flop synchronizer.
  - Debouncer: output level takes a new value once the synchronized input has held it for DEBOUNCE_CYCLES consecutive clocks.
  - Rising-edge detector: 1-cycle press pulse.
- Latency: a button held ≥1 cycle produces exactly one press pulse. The state update is visible on led/rgb no later than 4 clocks after the btn rising edge.
- A held button yields a single press; release produces nothing.
- Press evaluation:
  - A cycle with exactly one press pulse is a valid press.
  - More than one simultaneous pulse counts as a wrong press.
  - No pulse: hold state.
- States and led value:
  - LOCKED: led 0000.
  - GOT_S: led 0001.
  - GOT_SW: led 0011.
  - GOT_SWE: led 0111.
  - UNLOCKED: led 1111.
- Transitions:
  - LOCKED: S→GOT_S; any other press→LOCKED.
  - GOT_S: W→GOT_SW; S→GOT_S; other→LOCKED.
  - GOT_SW: E→GOT_SWE; S→GOT_S; other→LOCKED.
  - GOT_SWE: W→UNLOCKED; S→GOT_S; other→LOCKED.
  - UNLOCKED: N→LOCKED; all other presses ignored.
- rgb: 3'b010 (green) in UNLOCKED; 3'b100 (red) in every other state.
- sw[0]=1: synchronous clear to LOCKED each cycle while high; presses are ignored while high. Has priority over button presses.
- led and rgb are registered, decoded from state.

Optional Feature:
- Macro: DIGITAL_LOCK_LOCKOUT_EN.
- Defined:
  - A 2-bit wrong-attempt counter increments on each transition to LOCKED caused by a wrong press.
  - The counter clears on UNLOCKED, sw[0] or rst.
  - The third wrong attempt enters LOCKOUT for LOCKOUT_CYCLES clocks: all presses ignored, rgb=3'b001 (blue), led=4'b0000. Then LOCKED, counter 0.
  - sw[0] and rst abort LOCKOUT immediately.
- Undefined: no counter, no LOCKOUT state; wrong presses simply return to LOCKED.

Test Plan:
- Reset/clear: rst low, then sw=0001 for 1 cycle then 0000 -> led=0000, rgb=100.
- Unlock: presses S,W,E,W (each 1-cycle pulse, 4 idle cycles between) -> led steps 0001,0011,0111,1111; rgb=010 after the final W.
- Relock: from UNLOCKED press N -> led=0000, rgb=100. Pressing E or W in UNLOCKED first -> stays 1111/010.
- Wrong start: W, E, E from LOCKED -> led stays 0000, rgb=100.
- Wrong mid-sequence: S,W,E then N -> led 0001,0011,0111 then 0000; a further N -> stays 0000/100.
- Edge cases:
  - Button held 20 cycles -> single advance.
  - btn=1010 simultaneous from GOT_S -> LOCKED.
  - With DIGITAL_LOCK_LOCKOUT_EN, three wrong attempts -> rgb=001 for LOCKOUT_CYCLES, S ignored during lockout, then rgb=100.
